// File: rtl/spi_pkg.sv
// Shared definitions for the 16-bit SPI link: default frame width and serf state encoding.
package spi_pkg;

  localparam int SPI_WIDTH = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } serf_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with a third flop for edge detection of an asynchronous pin.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus delayed copy for edge compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_serf.sv
// SPI responder: shifts a command in on MOSI while returning the buffered response word on MISO.
module spi_serf
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SS_n,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             wrt,
  output logic [WIDTH-1:0] rd_data,
  output logic             done,
  output logic             frm_err
);

  localparam int CW = $clog2(WIDTH + 1) + 1;
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  serf_state_e      state_q, state_d;
  logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             mosi_meta_q, mosi_sync_q;
  logic [1:0]       settle_q, settle_d;
  logic             armed_q, armed_d;

  logic ss_sync_s, ss_rise_s, ss_fall_s;
  logic sclk_rise_s;
  logic sclk_sync_unused_s, sclk_fall_unused_s;

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (SS_n),
    .sync_o (ss_sync_s),
    .rise_o (ss_rise_s),
    .fall_o (ss_fall_s)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (SCLK),
    .sync_o (sclk_sync_unused_s),
    .rise_o (sclk_rise_s),
    .fall_o (sclk_fall_unused_s)
  );

  // MOSI gets the same two-stage delay as SCLK so data stays aligned with its sampling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      mosi_meta_q <= MOSI;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  // Frames are accepted only after SS_n has been seen high with a settled synchronizer,
  // so a frame already in flight when reset releases is ignored
  always_comb begin
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | ((settle_q == 2'd2) & ss_sync_s);
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tx_buf_d = wrt ? tx_data : tx_buf_q;
    case (state_q)
      IDLE: begin
        if (ss_fall_s && armed_q) begin
          shift_d = wrt ? tx_data : tx_buf_q;
          cnt_d   = {CW{1'b0}};
          state_d = ACTIVE;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (sclk_rise_s) begin
          shift_d = {shift_q[WIDTH-2:0], mosi_sync_q};
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end else begin
          shift_d = shift_q;
        end
        // The shift above is folded in before the end-of-frame length check
        if (ss_rise_s) begin
          if (cnt_d == CNT_FULL) begin
            rd_d   = shift_d;
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
          state_d = IDLE;
        end else begin
          state_d = ACTIVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame state, data path and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tx_buf_q <= {WIDTH{1'b0}};
      shift_q  <= {WIDTH{1'b0}};
      rd_q     <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_buf_q <= tx_buf_d;
      shift_q  <= shift_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      settle_q <= settle_d;
      armed_q  <= armed_d;
    end
  end

  assign MISO    = shift_q[WIDTH-1];
  assign rd_data = rd_q;
  assign done    = done_q;
  assign frm_err = err_q;

endmodule
